// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types and constants for the issue/writeback path.
// Writeback reservation entry, default latencies and writeback mux encodings.
package riscv_pipe_pkg;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_f;
    logic       src;
  } wb_entry_t;

  localparam int INT_LAT_DEF = 3;
  localparam int FPU_LAT_DEF = 5;

  localparam logic WB_SRC_INT = 1'b0;
  localparam logic WB_SRC_FPU = 1'b1;

endpackage

// File: rtl/issue_scoreboard_if.sv
// Decode-side handshake and writeback strobe bundle of the issue scoreboard.
// slave = scoreboard side, master = decode/register-file side.
interface issue_scoreboard_if;

  logic        dec_valid;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic        dec_rs1_en;
  logic        dec_rs2_en;
  logic        dec_rs1_f;
  logic        dec_rs2_f;
  logic [4:0]  dec_rd;
  logic        dec_rd_we;
  logic        dec_rd_f;
  logic        dec_fpu;
  logic        dec_stall;
  logic        dec_fire;
  logic        wb_we_x;
  logic        wb_we_f;
  logic [4:0]  wb_rd;
  logic        wb_src;
  logic [31:0] busy_x;
  logic [31:0] busy_f;

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_rs1_en, dec_rs2_en, dec_rs1_f, dec_rs2_f,
           dec_rd, dec_rd_we, dec_rd_f, dec_fpu,
    output dec_stall, dec_fire, wb_we_x, wb_we_f, wb_rd, wb_src, busy_x, busy_f
  );

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_rs1_en, dec_rs2_en, dec_rs1_f, dec_rs2_f,
           dec_rd, dec_rd_we, dec_rd_f, dec_fpu,
    input  dec_stall, dec_fire, wb_we_x, wb_we_f, wb_rd, wb_src, busy_x, busy_f
  );

endinterface

// File: rtl/reg_busy_table.sv
// 32-entry pending-write bitmap with two combinational read ports.
// A set and a clear of the same bit on the same edge leaves the bit set.
module reg_busy_table (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_set_en,
  input  logic [4:0]  i_set_idx,
  input  logic        i_clr_en,
  input  logic [4:0]  i_clr_idx,
  input  logic [4:0]  i_rd_a_idx,
  input  logic [4:0]  i_rd_b_idx,
  output logic        o_rd_a,
  output logic        o_rd_b,
  output logic [31:0] o_busy
);

  logic [31:0] r_busy;
  logic [31:0] w_set_mask;
  logic [31:0] w_clr_mask;

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_set_en) w_set_mask[i_set_idx] = 1'b1;
    if (i_clr_en) w_clr_mask[i_clr_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
  end

  assign o_rd_a = r_busy[i_rd_a_idx];
  assign o_rd_b = r_busy[i_rd_b_idx];
  assign o_busy = r_busy;

endmodule

// File: rtl/issue_scoreboard.sv
// Issue controller: reserves writeback slots for in-flight register writes,
// holds decode on RAW/WAW/write-port hazards and drives the register-file strobes.
module issue_scoreboard
  import riscv_pipe_pkg::*;
#(
  parameter int INT_LAT = INT_LAT_DEF,
  parameter int FPU_LAT = FPU_LAT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  issue_scoreboard_if.slave   bus
);

  wb_entry_t   r_slot [FPU_LAT];
  wb_entry_t   w_new;
  logic        w_need;
  logic        w_raw;
  logic        w_waw;
  logic        w_port;
  logic        w_stall;
  logic        w_fire;
  logic        w_wb_x;
  logic        w_wb_f;
  logic        w_rs1_bx, w_rs2_bx, w_rs1_bf, w_rs2_bf;
  logic [31:0] w_busy_x;
  logic [31:0] w_busy_f;

  always_comb begin
    // Integer x0 is hardwired; float f0 is a real register.
    w_need  = bus.dec_rd_we & ~(~bus.dec_rd_f & (bus.dec_rd == 5'd0));
    w_raw   = (bus.dec_rs1_en & (bus.dec_rs1_f ? w_rs1_bf : w_rs1_bx)) |
              (bus.dec_rs2_en & (bus.dec_rs2_f ? w_rs2_bf : w_rs2_bx));
    w_waw   = w_need & (bus.dec_rd_f ? w_busy_f[bus.dec_rd] : w_busy_x[bus.dec_rd]);
    // slot[INT_LAT] would shift into slot[INT_LAT-1] on the same edge.
    w_port  = w_need & ~bus.dec_fpu & r_slot[INT_LAT].valid;
    w_stall = bus.dec_valid & (w_raw | w_waw | w_port);
    w_fire  = bus.dec_valid & ~w_stall;

    w_new.valid = 1'b1;
    w_new.rd    = bus.dec_rd;
    w_new.is_f  = bus.dec_rd_f;
    w_new.src   = bus.dec_fpu ? WB_SRC_FPU : WB_SRC_INT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FPU_LAT; i++) r_slot[i] <= '0;
    end else begin
      for (int i = 0; i < FPU_LAT - 1; i++) r_slot[i] <= r_slot[i+1];
      r_slot[FPU_LAT-1] <= '0;
      if (w_fire && w_need) begin
        if (bus.dec_fpu) r_slot[FPU_LAT-1] <= w_new;
        else             r_slot[INT_LAT-1] <= w_new;
      end
    end
  end

  assign w_wb_x = r_slot[0].valid & ~r_slot[0].is_f;
  assign w_wb_f = r_slot[0].valid &  r_slot[0].is_f;

  reg_busy_table u_busy_x (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_set_en   (w_fire & w_need & ~bus.dec_rd_f),
    .i_set_idx  (bus.dec_rd),
    .i_clr_en   (w_wb_x),
    .i_clr_idx  (r_slot[0].rd),
    .i_rd_a_idx (bus.dec_rs1),
    .i_rd_b_idx (bus.dec_rs2),
    .o_rd_a     (w_rs1_bx),
    .o_rd_b     (w_rs2_bx),
    .o_busy     (w_busy_x)
  );

  reg_busy_table u_busy_f (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_set_en   (w_fire & w_need & bus.dec_rd_f),
    .i_set_idx  (bus.dec_rd),
    .i_clr_en   (w_wb_f),
    .i_clr_idx  (r_slot[0].rd),
    .i_rd_a_idx (bus.dec_rs1),
    .i_rd_b_idx (bus.dec_rs2),
    .o_rd_a     (w_rs1_bf),
    .o_rd_b     (w_rs2_bf),
    .o_busy     (w_busy_f)
  );

  assign bus.dec_stall = w_stall;
  assign bus.dec_fire  = w_fire;
  assign bus.wb_we_x   = w_wb_x;
  assign bus.wb_we_f   = w_wb_f;
  assign bus.wb_rd     = r_slot[0].rd;
  assign bus.wb_src    = r_slot[0].src;
  assign bus.busy_x    = w_busy_x;
  assign bus.busy_f    = w_busy_f;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed hazard scenarios plus random issue
// traffic, checked against a cycle-stamped pending-write model.
module tb_issue_scoreboard;

  localparam int INT_L = 3;
  localparam int FPU_L = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  issue_scoreboard_if bus();

  issue_scoreboard #(.INT_LAT(INT_L), .FPU_LAT(FPU_L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         wb;
    bit         f;
    logic [4:0] rd;
    bit         src;
  } pend_t;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_en;
    logic       rs1_f;
    logic       rs2_en;
    logic       rs2_f;
    logic [4:0] rd;
    logic       rd_we;
    logic       rd_f;
    logic       fpu;
  } ins_t;

  pend_t pq[$];
  pend_t eq[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit mbusy(input bit f, input logic [4:0] r);
    foreach (pq[i]) if (pq[i].f == f && pq[i].rd == r && pq[i].wb >= cyc) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit wb_taken(input int wb);
    foreach (pq[i]) if (pq[i].wb == wb) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model: a write is pending from its fire cycle up to and
  // including its writeback cycle (fire + latency).
  always @(negedge clk) begin
    bit need, raw, waw, port, stall;
    int lat;
    logic [31:0] ex_bx, ex_bf;
    pend_t p;
    if (!rst_n) begin
      pq.delete();
      eq.delete();
    end else begin
      for (int i = pq.size() - 1; i >= 0; i--) if (pq[i].wb < cyc) pq.delete(i);
      ex_bx = '0;
      ex_bf = '0;
      foreach (pq[i]) begin
        if (pq[i].f) ex_bf[pq[i].rd] = 1'b1;
        else         ex_bx[pq[i].rd] = 1'b1;
      end
      check("busy_x", bus.busy_x, ex_bx);
      check("busy_f", bus.busy_f, ex_bf);
      need  = bus.dec_rd_we && !(!bus.dec_rd_f && bus.dec_rd == 5'd0);
      lat   = bus.dec_fpu ? FPU_L : INT_L;
      raw   = (bus.dec_rs1_en && mbusy(bus.dec_rs1_f, bus.dec_rs1)) ||
              (bus.dec_rs2_en && mbusy(bus.dec_rs2_f, bus.dec_rs2));
      waw   = need && mbusy(bus.dec_rd_f, bus.dec_rd);
      port  = need && wb_taken(cyc + lat);
      stall = bus.dec_valid && (raw || waw || port);
      check("dec_stall", bus.dec_stall, stall);
      check("dec_fire", bus.dec_fire, bus.dec_valid && !stall);
      if (bus.dec_valid && !stall && need) begin
        p.wb  = cyc + lat;
        p.f   = bus.dec_rd_f;
        p.rd  = bus.dec_rd;
        p.src = bus.dec_fpu;
        pq.push_back(p);
        eq.push_back(p);
      end
    end
  end

  // Writeback monitor: matches each strobe against the expected-writeback queue.
  always @(negedge clk) begin
    int idx;
    idx = -1;
    if (!rst_n) begin
      check("rst_we", {bus.wb_we_x, bus.wb_we_f}, 0);
      check("rst_wb_rd", bus.wb_rd, 0);
      check("rst_wb_src", bus.wb_src, 0);
      check("rst_busy", bus.busy_x | bus.busy_f, 0);
      check("rst_stall", bus.dec_stall, 0);
      check("rst_fire", bus.dec_fire, bus.dec_valid);
    end else begin
      foreach (eq[i]) if (eq[i].wb == cyc) idx = i;
      if (bus.wb_we_x || bus.wb_we_f) begin
        if (idx < 0) begin
          check("wb_unexpected", {bus.wb_we_x, bus.wb_we_f}, 0);
        end else begin
          check("wb_we_x", bus.wb_we_x, !eq[idx].f);
          check("wb_we_f", bus.wb_we_f, eq[idx].f);
          check("wb_rd", bus.wb_rd, eq[idx].rd);
          check("wb_src", bus.wb_src, eq[idx].src);
          eq.delete(idx);
        end
      end else if (idx >= 0) begin
        check("wb_missing", {bus.wb_we_x, bus.wb_we_f}, eq[idx].f ? 1 : 2);
        eq.delete(idx);
      end
    end
  end

  function automatic ins_t mk(input logic [4:0] rd, input bit rd_we, input bit rd_f, input bit fpu,
                              input logic [4:0] rs1, input bit rs1_en, input bit rs1_f,
                              input logic [4:0] rs2, input bit rs2_en, input bit rs2_f);
    ins_t n;
    n.rd = rd; n.rd_we = rd_we; n.rd_f = rd_f; n.fpu = fpu;
    n.rs1 = rs1; n.rs1_en = rs1_en; n.rs1_f = rs1_f;
    n.rs2 = rs2; n.rs2_en = rs2_en; n.rs2_f = rs2_f;
    return n;
  endfunction

  task automatic drive(input ins_t n);
    bus.dec_rs1 = n.rs1; bus.dec_rs1_en = n.rs1_en; bus.dec_rs1_f = n.rs1_f;
    bus.dec_rs2 = n.rs2; bus.dec_rs2_en = n.rs2_en; bus.dec_rs2_f = n.rs2_f;
    bus.dec_rd  = n.rd;  bus.dec_rd_we  = n.rd_we;  bus.dec_rd_f  = n.rd_f;
    bus.dec_fpu = n.fpu;
  endtask

  // Presents an instruction and holds it until the DUT fires it; returns the fire cycle.
  task automatic present(input ins_t n, output int fc);
    drive(n);
    bus.dec_valid = 1'b1;
    fc = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.dec_fire === 1'b1) begin
        fc = cyc;
        break;
      end
    end
    if (fc < 0) check("fire_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.dec_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.dec_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int t0, t1, t2;
    ins_t r;
    drive(mk(5'd5, 1, 0, 0, 5'd1, 1, 0, 5'd2, 1, 0));
    bus.dec_valid = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    t0 = cyc;

    // add x5 right after reset, then sub x6, x5, x1
    present(mk(5'd5, 1, 0, 0, 5'd1, 1, 0, 5'd2, 1, 0), t1);
    check("reset_first_fire", t1, t0);
    present(mk(5'd6, 1, 0, 0, 5'd5, 1, 0, 5'd1, 1, 0), t2);
    check("int_raw_penalty", t2 - t1, 4);
    idle(8);

    // fadd f2, then add x7 presented two cycles later collides on the write port
    present(mk(5'd2, 1, 1, 1, 5'd1, 1, 1, 5'd1, 1, 1), t1);
    idle(1);
    present(mk(5'd7, 1, 0, 0, 5'd1, 1, 0, 5'd2, 1, 0), t2);
    check("port_conflict_fire", t2 - t1, 3);
    idle(8);

    // fmul f3 then fadd f3: WAW on the float file
    present(mk(5'd3, 1, 1, 1, 5'd1, 1, 1, 5'd2, 1, 1), t1);
    present(mk(5'd3, 1, 1, 1, 5'd1, 1, 1, 5'd1, 1, 1), t2);
    check("float_waw_fire", t2 - t1, 6);
    idle(8);

    // two addi x0 back to back: no reservation, no stall
    present(mk(5'd0, 1, 0, 0, 5'd1, 1, 0, 5'd0, 0, 0), t1);
    check("x0_busy", bus.busy_x, 0);
    present(mk(5'd0, 1, 0, 0, 5'd1, 1, 0, 5'd0, 0, 0), t2);
    check("x0_no_stall", t2 - t1, 1);

    // fadd f4 then a store reading f4
    present(mk(5'd4, 1, 1, 1, 5'd1, 1, 1, 5'd1, 1, 1), t1);
    present(mk(5'd9, 0, 0, 0, 5'd1, 1, 0, 5'd4, 1, 1), t2);
    check("store_raw_fire", t2 - t1, 6);
    idle(8);

    // random traffic over a small register set to provoke hazards
    for (int n = 0; n < 250; n++) begin
      r.rs1    = 5'($urandom_range(0, 7));
      r.rs2    = 5'($urandom_range(0, 7));
      r.rd     = 5'($urandom_range(0, 7));
      r.rs1_en = 1'($urandom_range(0, 1));
      r.rs2_en = 1'($urandom_range(0, 1));
      r.rs1_f  = 1'($urandom_range(0, 1));
      r.rs2_f  = 1'($urandom_range(0, 1));
      r.rd_we  = ($urandom_range(0, 4) != 0);
      r.rd_f   = 1'($urandom_range(0, 1));
      r.fpu    = 1'($urandom_range(0, 1));
      present(r, t1);
      if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 3));
    end
    idle(8);

    // reset with three float ops in flight
    present(mk(5'd1, 1, 1, 1, 5'd8, 1, 1, 5'd9, 1, 1), t1);
    present(mk(5'd2, 1, 1, 1, 5'd8, 1, 1, 5'd9, 1, 1), t1);
    present(mk(5'd3, 1, 1, 1, 5'd8, 1, 1, 5'd9, 1, 1), t1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy_x", bus.busy_x, 0);
    check("midrst_busy_f", bus.busy_f, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
